layout_skew_streamer: RTL and testbench
=======================================

# layout_skew_streamer

Sequential successor to the combinational skewed-layout block. It buffers a feature-map tile of up to DIM×DIM pixels row by row, then streams it to the systolic array as one diagonally skewed lane vector per cycle, with ready/valid backpressure on both sides. It sits between the feature-map SRAM reader and the array's operand-B edge. It adds runtime tile sizes, per-lane valid masks, a done pulse and an optional transposed mode.

## Interface
- `BITS`, default 8: pixel width.
- `DIM`, default 32: maximum tile dimension and lane count.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new tile; sampled only in IDLE.
- `n`  in  $clog2(DIM)+1  tile row count; sampled with `start`.
- `p`  in  $clog2(DIM)+1  tile column count; sampled with `start`.
- `transpose`  in  1  stream the transposed tile; sampled with `start`. Present only with `LAYOUT_TRANSPOSE_EN`.
- `busy`  out  1  high in LOAD and STREAM.
- `row_valid`  in  1  `row_data` is valid.
- `row_data`  in  DIM×BITS  one tile row; lane j is column j.
- `row_ready`  out  1  high in LOAD.
- `out_valid`  out  1  high in STREAM.
- `out_data`  out  DIM×BITS  skewed vector; masked lanes are 0.
- `out_mask`  out  DIM  per-lane valid.
- `out_last`  out  1  high on the final vector of a tile.
- `out_ready`  in  1  consumer accepts the vector.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- States: IDLE, LOAD, STREAM.
- IDLE + `start`:
  - Latch `n` and `p`, each saturated to DIM.
  - If either is 0, stay in IDLE and pulse `done` next cycle.
  - Otherwise go to LOAD, with row counter r=0.
- LOAD:
  - Each cycle with `row_valid && row_ready`, write `row_data` to buffer row r and increment r.
  - When row n-1 is accepted, go to STREAM with t=0.
  - Rows beyond `p` columns are stored but never emitted.
- STREAM, normal mode, lane j:
  - `out_mask[j]` = (j<p) && (0 ≤ t−j < n).
  - `out_data[j]` = buf[t−j][j] when masked in, else 0.
- STREAM, transpose mode, lane j:
  - `out_mask[j]` = (j<n) && (0 ≤ t−j < p).
  - `out_data[j]` = buf[j][t−j] when masked in, else 0.
- Vector count per tile: n+p−1 (t = 0 … n+p−2). `out_last` = (t == n+p−2).
- On each `out_valid && out_ready`, increment t. The transfer with `out_last` high returns the block to IDLE and pulses `done` in the next cycle.
- Held values:
  - `out_data`, `out_mask` and `out_last` hold stable while `out_valid && !out_ready`.
  - `out_data` and `out_mask` are 0 outside STREAM.
- Arithmetic:
  - t and r are $clog2(2·DIM) bits.
  - t−j is computed in signed width $clog2(2·DIM)+1, so negative results mask the lane out.
- `start` while busy is ignored.
- The buffer is not cleared between tiles. Stale data is unreachable because of masking.

## Timing
- Reset values: state IDLE, r=0, t=0. All outputs 0: `busy`, `row_ready`, `out_valid`, `out_data`, `out_mask`, `out_last`, `done`.
- Reset mid-LOAD or mid-STREAM aborts the tile immediately; no `done` is produced.
- Start latency: `start` in cycle k gives `busy`/`row_ready` high in cycle k+1.
- Load-to-stream latency: last row accepted in cycle k gives the first `out_valid` in cycle k+1.
- Throughput: 1 row per cycle during LOAD and 1 vector per cycle during STREAM with no stalls. Minimum tile time is 1+n+(n+p−1) cycles.
- `done` is high in the cycle after the last transfer, with state already IDLE. A `start` asserted in that same cycle is accepted.
- Output signals (`out_valid`, `out_data`, `out_mask`, `out_last`) are registered and read from the buffer, so there is no combinational path from `out_ready` to them.

## Configuration
- `LAYOUT_TRANSPOSE_EN` defined: the `transpose` port exists, and the transposed lane mapping and its sampling flop are compiled in.
- Not defined: the port is absent and the block always uses normal mode.

## Structure
- Package `layout_pkg` holds:
  - constants `LAYOUT_BITS` and `LAYOUT_DIM`;
  - typedef `dim_t` (logic [$clog2(DIM):0]);
  - typedef `pixel_t`;
  - enum `layout_state_e` {IDLE, LOAD, STREAM}.
- Sub-module `layout_skew_sel`: one lane's index and mask computation (inputs t, j, n, p, transpose; outputs row index, column index, mask). It is instantiated DIM times in a generate loop.

## Test plan
- n=p=32, random rows, `out_ready`=1: 63 vectors. Vector 0 has mask=0x1 and data[0]=buf[0][0]. Vector 62 has mask bit 31 only, data[31]=buf[31][31], and `out_last`=1. `done` pulses 1 cycle later.
- n=14, p=5: 18 vectors. Lanes 5–31 are always masked out and 0. Vector 13 has mask=0x1F.
- n=5, p=5 with `out_ready` toggling 1,0,0,1…: each vector holds stable while stalled. 9 transfers total, with no duplicates or drops.
- `LAYOUT_TRANSPOSE_EN`, n=3, p=2, transpose=1: 4 vectors. Vector 1 has data[0]=buf[0][1] and data[1]=buf[1][0], mask=0x3.
- n=0, p=7 `start`: no LOAD, `done` pulses next cycle, `busy` stays 0. Then n=40: saturates to 32, so 32 rows are accepted.
- Assert `rst` during STREAM at t=3: all outputs are 0 the same cycle, the block is IDLE, and no `done` occurs. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/layout_pkg.sv
// Shared constants, types and FSM state encoding for the skewed-layout streamer.
package layout_pkg;

  localparam int LAYOUT_BITS = 8;
  localparam int LAYOUT_DIM  = 32;

  typedef logic [$clog2(LAYOUT_DIM):0] dim_t;
  typedef logic [LAYOUT_BITS-1:0]      pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } layout_state_e;

endpackage

// File: rtl/layout_skew_sel.sv
// One lane of the diagonal skew: maps stream step t and lane j to a buffer
// coordinate and decides whether the lane carries a real pixel this step.
module layout_skew_sel
  import layout_pkg::*;
#(
  parameter int  DIM = LAYOUT_DIM,
  localparam int TW  = $clog2(2*DIM),
  localparam int NW  = $clog2(DIM) + 1,
  localparam int IW  = $clog2(DIM)
) (
  input  logic [TW-1:0] t,
  input  logic [TW-1:0] j,
  input  logic [NW-1:0] n,
  input  logic [NW-1:0] p,
  input  logic          transpose,
  output logic [IW-1:0] row_idx,
  output logic [IW-1:0] col_idx,
  output logic          mask
);

  logic signed [TW:0] d;
  logic signed [TW:0] j_s;
  logic signed [TW:0] n_s;
  logic signed [TW:0] p_s;

  // One extra bit keeps t-j negative for lanes the wavefront has not reached yet.
  assign j_s = $signed({1'b0, j});
  assign n_s = $signed((TW+1)'(n));
  assign p_s = $signed((TW+1)'(p));
  assign d   = $signed({1'b0, t}) - j_s;

  always_comb begin
    row_idx = d[IW-1:0];
    col_idx = j[IW-1:0];
    mask    = (j_s < p_s) && (d >= 0) && (d < n_s);
    if (transpose) begin
      row_idx = j[IW-1:0];
      col_idx = d[IW-1:0];
      mask    = (j_s < n_s) && (d >= 0) && (d < p_s);
    end
  end

endmodule

// File: rtl/layout_skew_streamer.sv
// Buffers an n x p tile row by row, then streams it as diagonally skewed lane vectors.
// Define LAYOUT_TRANSPOSE_EN to add the transpose port and transposed lane mapping.
module layout_skew_streamer
  import layout_pkg::*;
#(
  parameter int  BITS = LAYOUT_BITS,
  parameter int  DIM  = LAYOUT_DIM,
  localparam int TW   = $clog2(2*DIM),
  localparam int NW   = $clog2(DIM) + 1,
  localparam int IW   = $clog2(DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NW-1:0]       n,
  input  logic [NW-1:0]       p,
`ifdef LAYOUT_TRANSPOSE_EN
  input  logic                transpose,
`endif
  output logic                busy,
  input  logic                row_valid,
  input  logic [DIM*BITS-1:0] row_data,
  output logic                row_ready,
  output logic                out_valid,
  output logic [DIM*BITS-1:0] out_data,
  output logic [DIM-1:0]      out_mask,
  output logic                out_last,
  input  logic                out_ready,
  output logic                done
);

  function automatic logic [NW-1:0] sat_dim(input logic [NW-1:0] x);
    return (x > NW'(DIM)) ? NW'(DIM) : x;
  endfunction

  layout_state_e         state_q, state_d;
  logic [TW-1:0]         r_q, r_d, t_q, t_d;
  logic [NW-1:0]         n_q, n_d, p_q, p_d;
  logic                  done_q, done_d;
  logic                  load_vec, clr_vec, row_acc, tr_sel;
  logic [NW-1:0]         n_sat, p_sat;
  logic [TW-1:0]         last_t;
  logic [DIM*BITS-1:0]   out_data_q, vec_data;
  logic [DIM-1:0]        out_mask_q, vec_mask;
  logic                  out_last_q;
  logic [BITS-1:0]       row_arr [DIM];
  logic [BITS-1:0]       mem_q   [DIM][DIM];

  assign n_sat   = sat_dim(n);
  assign p_sat   = sat_dim(p);
  assign last_t  = TW'(n_q) + TW'(p_q) - TW'(2);
  assign row_acc = (state_q == LOAD) && row_valid;

`ifdef LAYOUT_TRANSPOSE_EN
  logic tr_q, tr_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tr_q <= 1'b0;
    else     tr_q <= tr_d;
  end
  assign tr_sel = tr_q;
`else
  assign tr_sel = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    t_d      = t_q;
    n_d      = n_q;
    p_d      = p_q;
    done_d   = 1'b0;
    load_vec = 1'b0;
    clr_vec  = 1'b0;
`ifdef LAYOUT_TRANSPOSE_EN
    tr_d     = tr_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        n_d = n_sat;
        p_d = p_sat;
`ifdef LAYOUT_TRANSPOSE_EN
        tr_d = transpose;
`endif
        if (n_sat == '0 || p_sat == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = LOAD;
          r_d     = '0;
        end
      end
      LOAD: if (row_valid) begin
        r_d = r_q + TW'(1);
        if (r_q == TW'(n_q) - TW'(1)) begin
          state_d  = STREAM;
          t_d      = '0;
          load_vec = 1'b1;
        end
      end
      STREAM: if (out_ready) begin
        if (out_last_q) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
          clr_vec = 1'b1;
        end else begin
          t_d      = t_q + TW'(1);
          load_vec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output vectors are prepared one step ahead from t_d so nothing combinational follows out_ready.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic [IW-1:0]   ri, ci;
    logic [BITS-1:0] pix;
    assign row_arr[j] = row_data[j*BITS +: BITS];
    layout_skew_sel #(.DIM(DIM)) u_sel (
      .t        (t_d),
      .j        (TW'(j)),
      .n        (n_q),
      .p        (p_q),
      .transpose(tr_sel),
      .row_idx  (ri),
      .col_idx  (ci),
      .mask     (vec_mask[j])
    );
    // A one-row tile reads the row being written in the same cycle.
    assign pix = (row_acc && ri == r_q[IW-1:0]) ? row_arr[ci] : mem_q[ri][ci];
    assign vec_data[j*BITS +: BITS] = vec_mask[j] ? pix : '0;
  end

  always_ff @(posedge clk) begin
    if (row_acc) mem_q[r_q[IW-1:0]] <= row_arr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      t_q        <= '0;
      n_q        <= '0;
      p_q        <= '0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      t_q     <= t_d;
      n_q     <= n_d;
      p_q     <= p_d;
      done_q  <= done_d;
      if (clr_vec) begin
        out_data_q <= '0;
        out_mask_q <= '0;
        out_last_q <= 1'b0;
      end else if (load_vec) begin
        out_data_q <= vec_data;
        out_mask_q <= vec_mask;
        out_last_q <= (t_d == last_t);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign row_ready = (state_q == LOAD);
  assign out_valid = (state_q == STREAM);
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_layout_skew_streamer.sv
// Randomized bench for layout_skew_streamer with a tile-level reference model.
module tb_layout_skew_streamer;

  localparam int BITS = 8;
  localparam int DIM  = 32;
  localparam int NW   = $clog2(DIM) + 1;
  localparam int W    = DIM * BITS;

  logic          clk, rst, start, busy, row_valid, row_ready;
  logic          out_valid, out_last, out_ready, done;
  logic [NW-1:0] n, p;
  logic [W-1:0]  row_data, out_data;
  logic [DIM-1:0] out_mask;
`ifdef LAYOUT_TRANSPOSE_EN
  logic          transpose;
`endif

  layout_skew_streamer #(.BITS(BITS), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .p        (p),
`ifdef LAYOUT_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .busy     (busy),
    .row_valid(row_valid),
    .row_data (row_data),
    .row_ready(row_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_mask (out_mask),
    .out_last (out_last),
    .out_ready(out_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int satf(input int x);
    return (x > DIM) ? DIM : x;
  endfunction

  // Reference model: phase 0=idle 1=loading 2=streaming, vi = vector index on the outputs.
  int phase = 0, rc = 0, vi = 0, mn = 0, mp = 0, sn, sp, rr, cc;
  bit mtr = 1'b0, done_exp = 1'b0, dn;
  logic [BITS-1:0] mtile [DIM][DIM];
  logic [W-1:0]    ed;
  logic [DIM-1:0]  em;
  logic [DIM-1:0]  cap_mask [64];
  logic [BITS-1:0] cap_l0 [64], cap_l1 [64], cap_l31 [64];
  bit              cap_last [64];
  int xfer_cnt = 0, row_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", W'(busy), '0);
      chk("rst_row_ready", W'(row_ready), '0);
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_out_mask", W'(out_mask), '0);
      chk("rst_out_last", W'(out_last), '0);
      chk("rst_done", W'(done), '0);
      phase    = 0;
      done_exp = 1'b0;
    end else begin
      if (done) done_cnt++;
      chk("done", W'(done), W'(done_exp));
      chk("busy", W'(busy), W'(phase != 0));
      chk("row_ready", W'(row_ready), W'(phase == 1));
      chk("out_valid", W'(out_valid), W'(phase == 2));
      if (phase == 2) begin
        ed = '0;
        em = '0;
        for (int j = 0; j < DIM; j++) begin
          if (!mtr) begin
            rr = vi - j; cc = j;
            em[j] = (j < mp) && (rr >= 0) && (rr < mn);
          end else begin
            rr = j; cc = vi - j;
            em[j] = (j < mn) && (cc >= 0) && (cc < mp);
          end
          if (em[j]) ed[j*BITS +: BITS] = mtile[rr][cc];
        end
        chk("out_data", out_data, ed);
        chk("out_mask", W'(out_mask), W'(em));
        chk("out_last", W'(out_last), W'(vi == mn + mp - 2));
      end else begin
        chk("idle_out_data", out_data, '0);
        chk("idle_out_mask", W'(out_mask), '0);
      end
      dn = 1'b0;
      case (phase)
        0: if (start) begin
          sn = satf(int'(n));
          sp = satf(int'(p));
          if (sn == 0 || sp == 0) dn = 1'b1;
          else begin
            phase = 1; rc = 0; mn = sn; mp = sp;
`ifdef LAYOUT_TRANSPOSE_EN
            mtr = transpose;
`else
            mtr = 1'b0;
`endif
          end
        end
        1: if (row_valid) begin
          for (int c = 0; c < DIM; c++) mtile[rc][c] = row_data[c*BITS +: BITS];
          rc++;
          row_cnt++;
          if (rc == mn) begin phase = 2; vi = 0; end
        end
        2: if (out_ready) begin
          cap_mask[vi] = out_mask;
          cap_l0[vi]   = out_data[0 +: BITS];
          cap_l1[vi]   = out_data[BITS +: BITS];
          cap_l31[vi]  = out_data[31*BITS +: BITS];
          cap_last[vi] = out_last;
          xfer_cnt++;
          if (vi == mn + mp - 2) begin phase = 0; dn = 1'b1; end
          else vi++;
        end
        default: phase = 0;
      endcase
      done_exp = dn;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_row;
    for (int k = 0; k < W/32; k++) row_data[k*32 +: 32] = $urandom;
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random. vmode: 0 rows back to back, 1 gaps.
  task automatic run_tile(input int nn, input int pp, input bit tr, input int rmode,
                          input int vmode, input int budget);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    xfer_cnt = 0;
    start = 1'b1;
    n = NW'(nn);
    p = NW'(pp);
`ifdef LAYOUT_TRANSPOSE_EN
    transpose = tr;
`else
    if (tr) $display("note: transpose requested in a build without it");
`endif
    tick;
    start = 1'b0;
    while (done_cnt == d0 && k < budget) begin
      row_valid = (vmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      rand_row;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = $urandom_range(1) != 0;
      endcase
      tick;
      k++;
    end
    row_valid = 1'b0;
    out_ready = 1'b1;
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL tile_timeout: n=%0d p=%0d no done within %0d cycles", nn, pp, budget);
    end
  endtask

  initial begin
    int d0, r0, k;
    rst = 1'b1; start = 1'b0; n = '0; p = '0; row_valid = 1'b0; row_data = '0; out_ready = 1'b1;
`ifdef LAYOUT_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    tick; tick; tick;
    rst = 1'b0;
    tick;

    // Full 32x32 tile, no stalls.
    d0 = done_cnt;
    run_tile(32, 32, 1'b0, 0, 0, 300);
    chk("full_xfers", W'(xfer_cnt), W'(63));
    chk("full_done_cnt", W'(done_cnt - d0), W'(1));
    chk("full_v0_mask", W'(cap_mask[0]), W'(32'h0000_0001));
    chk("full_v0_lane0", W'(cap_l0[0]), W'(mtile[0][0]));
    chk("full_v62_mask", W'(cap_mask[62]), W'(32'h8000_0000));
    chk("full_v62_lane31", W'(cap_l31[62]), W'(mtile[31][31]));
    chk("full_v62_last", W'(cap_last[62]), W'(1));
    chk("full_v61_last", W'(cap_last[61]), W'(0));

    // Tall narrow tile.
    run_tile(14, 5, 1'b0, 0, 1, 300);
    chk("n14p5_xfers", W'(xfer_cnt), W'(18));
    chk("n14p5_v13_mask", W'(cap_mask[13]), W'(32'h0000_001F));
    chk("n14p5_v17_mask", W'(cap_mask[17]), W'(32'h0000_0010));

    // Stalled consumer.
    run_tile(5, 5, 1'b0, 1, 0, 300);
    chk("stall_xfers", W'(xfer_cnt), W'(9));

`ifdef LAYOUT_TRANSPOSE_EN
    run_tile(3, 2, 1'b1, 0, 0, 100);
    chk("tr_xfers", W'(xfer_cnt), W'(4));
    chk("tr_v1_mask", W'(cap_mask[1]), W'(32'h3));
    chk("tr_v1_lane0", W'(cap_l0[1]), W'(mtile[0][1]));
    chk("tr_v1_lane1", W'(cap_l1[1]), W'(mtile[1][0]));
`endif

    // Empty tile, then saturating row count.
    d0 = done_cnt;
    r0 = row_cnt;
    run_tile(0, 7, 1'b0, 0, 0, 10);
    chk("empty_done_cnt", W'(done_cnt - d0), W'(1));
    chk("empty_rows", W'(row_cnt - r0), W'(0));
    r0 = row_cnt;
    run_tile(40, 3, 1'b0, 0, 0, 300);
    chk("sat_rows", W'(row_cnt - r0), W'(32));
    chk("sat_xfers", W'(xfer_cnt), W'(34));

    // Reset in the middle of streaming.
    d0 = done_cnt;
    start = 1'b1; n = NW'(6); p = NW'(6);
    tick;
    start = 1'b0; row_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (!(phase == 2 && vi == 3) && k < 200) begin
      rand_row;
      tick;
      k++;
    end
    chk("rst_reach_t3", W'(phase == 2 && vi == 3), W'(1));
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    row_valid = 1'b0;
    tick; tick; tick;
    chk("rst_no_done", W'(done_cnt - d0), W'(0));
    run_tile(4, 7, 1'b0, 0, 0, 100);
    chk("after_rst_xfers", W'(xfer_cnt), W'(10));

    // Random tiles with random stalls on both sides.
    for (int i = 0; i < 8; i++) begin
      int rn, rp, rx;
      rn = $urandom_range(1, DIM);
      rp = $urandom_range(1, DIM);
      run_tile(rn, rp, 1'b0, 2, 1, 1000);
      rx = rn + rp - 1;
      chk("rand_xfers", W'(xfer_cnt), W'(rx));
    end

    tick; tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
